// File: rtl/mem_ctrl_if.sv
// Bundle shared by the fetch stage, the MEM stage, mem_ctrl and the byte-wide RAM port.
// The slave modport is the controller's view; master is the view of everything around it.
interface mem_ctrl_if;
  logic        if_enable_i;
  logic [31:0] if_addr_i;
  logic        if_jump_i;
  logic        is_if_output_o;
  logic        inst_ready_o;
  logic [31:0] inst_o;

  logic        mem_enable_i;
  logic        mem_wr_i;
  logic [31:0] mem_addr_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_data_i;
  logic        mem_ready_o;
  logic [31:0] mem_data_o;

  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  modport slave (
    input  if_enable_i, if_addr_i, if_jump_i,
    input  mem_enable_i, mem_wr_i, mem_addr_i, mem_len_i, mem_data_i,
    input  ram_din_i,
    output is_if_output_o, inst_ready_o, inst_o,
    output mem_ready_o, mem_data_o,
    output ram_dout_o, ram_a_o, ram_wr_o
  );

  modport master (
    output if_enable_i, if_addr_i, if_jump_i,
    output mem_enable_i, mem_wr_i, mem_addr_i, mem_len_i, mem_data_i,
    output ram_din_i,
    input  is_if_output_o, inst_ready_o, inst_o,
    input  mem_ready_o, mem_data_o,
    input  ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM between instruction fetch and MEM-stage loads/stores,
// serializing each access into little-endian byte transfers with a one-cycle ready pulse.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ram_a_q, ram_a_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        inst_ready_q, inst_ready_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic [2:0]  next_k;
  logic [1:0]  cap_idx;
  logic [2:0]  mem_nbytes;

  // RAM data lags its address by one cycle, so the byte arriving now belongs to index cnt-1.
  assign next_k     = cnt_q + 3'd1;
  assign cap_idx    = cnt_q[1:0] - 2'd1;
  assign mem_nbytes = (bus.mem_len_i == 2'd0) ? 3'd1 :
                      (bus.mem_len_i == 2'd1) ? 3'd2 : 3'd4;

  assign bus.is_if_output_o = (state_q == IF_READ) || ((state_q == IDLE) && !bus.mem_enable_i);
  assign bus.inst_ready_o   = inst_ready_q;
  assign bus.inst_o         = inst_q;
  assign bus.mem_ready_o    = mem_ready_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.ram_a_o        = ram_a_q;
  assign bus.ram_wr_o       = ram_wr_q;
  assign bus.ram_dout_o     = ram_dout_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ram_a_d      = 32'd0;
    ram_wr_d     = 1'b0;
    ram_dout_d   = 8'd0;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    mem_ready_d  = 1'b0;
    mem_data_d   = mem_data_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_enable_i) begin
          base_d   = bus.mem_addr_i;
          wdata_d  = bus.mem_data_i;
          nbytes_d = mem_nbytes;
          cnt_d    = 3'd0;
          rdata_d  = 32'd0;
          ram_a_d  = bus.mem_addr_i;
          if (bus.mem_wr_i) begin
            state_d    = MEM_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_data_i[7:0];
          end else begin
            state_d = MEM_READ;
          end
        end else if (bus.if_enable_i && !bus.if_jump_i) begin
          state_d  = IF_READ;
          base_d   = bus.if_addr_i;
          nbytes_d = 3'd4;
          cnt_d    = 3'd0;
          rdata_d  = 32'd0;
          ram_a_d  = bus.if_addr_i;
        end
      end

      IF_READ, MEM_READ: begin
        if ((state_q == IF_READ) && bus.if_jump_i) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            rdata_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
          end
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_READ) begin
              inst_ready_d = 1'b1;
              inst_d       = rdata_d;
            end else begin
              mem_ready_d = 1'b1;
              mem_data_d  = rdata_d;
            end
          end else begin
            cnt_d = next_k;
            if (next_k < nbytes_q) begin
              ram_a_d = base_q + {29'd0, next_k};
            end
          end
        end
      end

      MEM_WRITE: begin
        if (next_k < nbytes_q) begin
          cnt_d      = next_k;
          ram_wr_d   = 1'b1;
          ram_a_d    = base_q + {29'd0, next_k};
          ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
        end else begin
          state_d     = IDLE;
          cnt_d       = 3'd0;
          mem_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      nbytes_q     <= 3'd0;
      base_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      ram_a_q      <= 32'd0;
      ram_wr_q     <= 1'b0;
      ram_dout_q   <= 8'd0;
      inst_ready_q <= 1'b0;
      inst_q       <= 32'd0;
      mem_ready_q  <= 1'b0;
      mem_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ram_a_q      <= ram_a_d;
      ram_wr_q     <= ram_wr_d;
      ram_dout_q   <= ram_dout_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      mem_ready_q  <= mem_ready_d;
      mem_data_q   <= mem_data_d;
    end
  end

endmodule
